// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter and its future RX sibling.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd6
    } state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    // Wide enough to count up to 9 data bits.
    localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each period.
// Clearing holds the count at zero, so a new frame always starts on a fresh period.
module baud_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);
    import fifo_uart_pkg::*;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = w_wrap && !i_clear;

    // Free-running period counter, restarted on clear and on every wrap.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a registered-output FIFO: 1 start bit, DATA_BITS
// data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit enabled by defining FIFO_UART_TX_PARITY_EN.
//
//   state  | meaning
//   IDLE   | line high, waiting for enable && fifo_nempty
//   POP    | fifo_pop high for this single cycle
//   LOAD   | FIFO output now valid; capture word, drive start bit
//   START  | start bit on the line
//   DATA   | shifting data bits out LSB first
//   PARITY | parity bit on the line (optional)
//   STOP   | stop bit(s); last cycle decides back-to-back POP or IDLE
module fifo_uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_fifo_nempty,
    output logic                 o_fifo_pop,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    output logic                 o_tx,
    output logic                 o_busy
`ifdef FIFO_UART_TX_PARITY_EN
    ,
    input  logic                 i_parity_odd
`endif
);
    import fifo_uart_pkg::*;

    state_t                 r_state;
    state_t                 w_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_tx;
    logic                   w_tick;
    logic                   w_clear;
    logic                   w_go;
    logic                   w_last_data;
    logic                   w_last_stop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    assign w_go        = i_enable && i_fifo_nempty;
    assign w_last_data = (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1));
    assign o_tx        = r_tx;

    baud_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the state-decoded outputs.
    always_comb begin
        w_next     = r_state;
        o_fifo_pop = 1'b0;
        o_busy     = (r_state != ST_IDLE);
        w_clear    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (w_go) w_next = ST_POP;
            end
            ST_POP: begin
                w_clear    = 1'b1;
                o_fifo_pop = 1'b1;
                w_next     = ST_LOAD;
            end
            ST_LOAD: begin
                w_clear = 1'b1;
                w_next  = ST_START;
            end
            ST_START: begin
                if (w_tick) w_next = ST_DATA;
            end
            ST_DATA: begin
`ifdef FIFO_UART_TX_PARITY_EN
                if (w_tick && w_last_data) w_next = ST_PARITY;
`else
                if (w_tick && w_last_data) w_next = ST_STOP;
`endif
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick && w_last_stop) w_next = w_go ? ST_POP : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Serial datapath: the next line level is registered on each bit boundary.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= TX_IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_shift   <= i_fifo_data;
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity  <= (^i_fifo_data) ^ i_parity_odd;
`endif
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (w_last_data) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            r_tx <= r_parity;
`else
                            r_tx <= TX_IDLE_LEVEL;
`endif
                            r_bit_cnt <= '0;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx      <= TX_IDLE_LEVEL;
                        r_bit_cnt <= '0;
                    end
                end
`endif
                ST_STOP: begin
                    r_tx <= TX_IDLE_LEVEL;
                    if (w_tick) begin
                        r_bit_cnt <= w_last_stop ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx <= TX_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
